// File: rtl/lap_stopwatch_pkg.sv
// Shared constants for the lap stopwatch: 7-segment patterns and BCD digit limits.
// Pattern bit order is {dp,g,f,e,d,c,b,a}, active-high.
// seg_decode() maps a BCD code to its pattern; codes A-F blank the digit.
package lap_stopwatch_pkg;

    localparam logic [7:0] SEG_BLANK = 8'h00;
    localparam logic [7:0] SEG_DP    = 8'h80;

    localparam logic [3:0] BCD_MAX_DEC  = 4'd9;
    localparam logic [3:0] BCD_MAX_MIN6 = 4'd5;

    // Entry d is the pattern for digit d (entry 0 is the rightmost literal).
    localparam logic [9:0][7:0] SEG_DIGIT = {
        8'h6F, 8'h7F, 8'h07, 8'h7D, 8'h6D,
        8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
    };

    function automatic logic [7:0] seg_decode(input logic [3:0] d);
        logic [7:0] r;
        r = SEG_BLANK;
        if (d < 4'd10) begin
            r = SEG_DIGIT[d];
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit_cnt.sv
// One BCD digit of the stopwatch, counting 0..MAX and rolling to 0 on increment at MAX.
// Ports: Clk, Reset (sync, active-high), Clr (sync zero), Inc (step) -> Q (digit), At_max.
// At_max is combinational from the register so the parent can ripple carries in one cycle.
module bcd_digit_cnt
    import lap_stopwatch_pkg::*;
#(
    parameter logic [3:0] MAX = BCD_MAX_DEC
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Clr,
    input  logic       Inc,
    output logic [3:0] Q,
    output logic       At_max
);

    logic [3:0] q_q;
    logic [3:0] q_d;

    assign At_max = (q_q == MAX);
    assign Q      = q_q;

    always_comb begin
        q_d = q_q;
        if (Clr) begin
            q_d = 4'd0;
        end else if (Inc) begin
            q_d = At_max ? 4'd0 : q_q + 4'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            q_q <= 4'd0;
        end else begin
            q_q <= q_d;
        end
    end

endmodule

// File: rtl/lap_stopwatch.sv
// Multi-digit BCD stopwatch with tick prescaler, ripple carry, lap freeze and overflow handling.
// Ports: Clk, Reset, Start/Clear/Lap pulses in; Count_bcd, Seg, Running, Lap_active, Overflow out.
// Seg is registered: it trails Count_bcd by one cycle, or holds a lap snapshot while frozen.
module lap_stopwatch
    import lap_stopwatch_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 10,
    parameter int MMSS_MODE  = 0,
    parameter int WRAP       = 0
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    Start,
    input  logic                    Clear,
    input  logic                    Lap,
    output logic [NUM_DIGITS*4-1:0] Count_bcd,
    output logic [NUM_DIGITS*8-1:0] Seg,
    output logic                    Running,
    output logic                    Lap_active,
    output logic                    Overflow
);

    localparam int             PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  PRE_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic          running_q, running_d;
    logic          lap_q, lap_d;
    logic          ovf_q, ovf_d;

    logic [NUM_DIGITS-1:0][7:0] seg_q, seg_d;
    logic [NUM_DIGITS-1:0][3:0] digit_q;
    logic [NUM_DIGITS-1:0][3:0] count_d;
    logic [NUM_DIGITS-1:0]      at_max;
    logic [NUM_DIGITS-1:0]      inc;

    logic tick;
    logic clear_ok;
    logic all_max;
    logic full_tick;

    // Clear looks at the current run state, before any same-cycle Start toggle.
    assign clear_ok  = Clear && !running_q;
    assign tick      = running_q && (presc_q == PRE_LAST);
    assign all_max   = &at_max;
    assign full_tick = tick && all_max;

    // Prescaler freezes while stopped so a resume continues mid-period.
    always_comb begin
        presc_d = presc_q;
        if (clear_ok) begin
            presc_d = '0;
        end else if (running_q) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
        end
    end

    // Ripple carry: digit k steps when every lower digit is at max.
    // In saturate mode a tick at full count must not move any digit.
    always_comb begin
        logic carry;
        carry = tick && !(all_max && (WRAP == 0));
        for (int k = 0; k < NUM_DIGITS; k++) begin
            inc[k] = carry;
            carry  = carry && at_max[k];
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_DIGITS; g++) begin : g_digit
            localparam logic [3:0] DMAX =
                ((MMSS_MODE != 0) && (g == 2)) ? BCD_MAX_MIN6 : BCD_MAX_DEC;

            bcd_digit_cnt #(.MAX(DMAX)) u_digit (
                .Clk    (Clk),
                .Reset  (Reset),
                .Clr    (clear_ok),
                .Inc    (inc[g]),
                .Q      (digit_q[g]),
                .At_max (at_max[g])
            );

            // Value each digit takes this edge; needed for the lap snapshot.
            always_comb begin
                count_d[g] = digit_q[g];
                if (clear_ok) begin
                    count_d[g] = 4'd0;
                end else if (inc[g]) begin
                    count_d[g] = at_max[g] ? 4'd0 : digit_q[g] + 4'd1;
                end
            end
        end
    endgenerate

    // A tick at full count in saturate mode stops the counter, overriding Start.
    always_comb begin
        running_d = running_q ^ Start;
        if (full_tick && (WRAP == 0)) begin
            running_d = 1'b0;
        end
    end

    always_comb begin
        ovf_d = ovf_q | full_tick;
        if (clear_ok) begin
            ovf_d = 1'b0;
        end
    end

    // Lap toggles while running; while stopped it can only release a freeze.
    always_comb begin
        lap_d = lap_q;
        if (clear_ok) begin
            lap_d = 1'b0;
        end else if (Lap) begin
            lap_d = running_q ? !lap_q : 1'b0;
        end
    end

    // Freezing captures the count being written now; otherwise follow the live register.
    always_comb begin
        seg_d = seg_q;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (lap_d && !lap_q) begin
                seg_d[k] = seg_decode(count_d[k]) | ((k == 1) ? SEG_DP : SEG_BLANK);
            end else if (!lap_d) begin
                seg_d[k] = seg_decode(digit_q[k]) | ((k == 1) ? SEG_DP : SEG_BLANK);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            presc_q   <= '0;
            running_q <= 1'b0;
            lap_q     <= 1'b0;
            ovf_q     <= 1'b0;
            for (int k = 0; k < NUM_DIGITS; k++) begin
                seg_q[k] <= seg_decode(4'd0) | ((k == 1) ? SEG_DP : SEG_BLANK);
            end
        end else begin
            presc_q   <= presc_d;
            running_q <= running_d;
            lap_q     <= lap_d;
            ovf_q     <= ovf_d;
            seg_q     <= seg_d;
        end
    end

    assign Count_bcd  = digit_q;
    assign Seg        = seg_q;
    assign Running    = running_q;
    assign Lap_active = lap_q;
    assign Overflow   = ovf_q;

endmodule

// File: tb/tb_lap_stopwatch.sv
module tb_lap_stopwatch;

    localparam int DIV = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic clr = 1'b0;
    logic lap = 1'b0;

    logic [15:0] cnt  [3];
    logic [31:0] seg  [3];
    logic        run  [3];
    logic        lapa [3];
    logic        ovf  [3];

    always #5 clk = ~clk;

    // 0: decimal, saturate   1: mm:ss, saturate   2: decimal, wrap
    lap_stopwatch #(.NUM_DIGITS(4), .TICK_DIV(DIV), .MMSS_MODE(0), .WRAP(0)) dut_a (
        .Clk(clk), .Reset(rst), .Start(start), .Clear(clr), .Lap(lap),
        .Count_bcd(cnt[0]), .Seg(seg[0]), .Running(run[0]),
        .Lap_active(lapa[0]), .Overflow(ovf[0]));
    lap_stopwatch #(.NUM_DIGITS(4), .TICK_DIV(DIV), .MMSS_MODE(1), .WRAP(0)) dut_b (
        .Clk(clk), .Reset(rst), .Start(start), .Clear(clr), .Lap(lap),
        .Count_bcd(cnt[1]), .Seg(seg[1]), .Running(run[1]),
        .Lap_active(lapa[1]), .Overflow(ovf[1]));
    lap_stopwatch #(.NUM_DIGITS(4), .TICK_DIV(DIV), .MMSS_MODE(0), .WRAP(1)) dut_c (
        .Clk(clk), .Reset(rst), .Start(start), .Clear(clr), .Lap(lap),
        .Count_bcd(cnt[2]), .Seg(seg[2]), .Running(run[2]),
        .Lap_active(lapa[2]), .Overflow(ovf[2]));

    int total = 0;
    int bad   = 0;

    // ---------------- behavioural model ----------------
    // The count is kept as a plain number of elapsed ticks; BCD is derived by division.
    int mod_c [3] = '{10000, 6000, 10000};
    bit mm_c  [3] = '{1'b0, 1'b1, 1'b0};
    bit wr_c  [3] = '{1'b0, 1'b0, 1'b1};

    logic [7:0] tbl [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                             8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

    int          n_m   [3];
    int          p_m   [3];
    bit          run_m [3];
    bit          lap_m [3];
    bit          ovf_m [3];
    logic [31:0] seg_m [3];
    bit          model_ok = 1'b0;

    function automatic logic [15:0] to_bcd(input int n, input bit mm);
        int d0, d1, d2, d3;
        d0 = n % 10;
        d1 = (n / 10) % 10;
        if (mm) begin
            d2 = (n / 100) % 6;
            d3 = (n / 600) % 10;
        end else begin
            d2 = (n / 100) % 10;
            d3 = (n / 1000) % 10;
        end
        return {d3[3:0], d2[3:0], d1[3:0], d0[3:0]};
    endfunction

    function automatic logic [31:0] seg_of(input logic [15:0] b);
        logic [31:0] r;
        logic [3:0]  d;
        for (int k = 0; k < 4; k++) begin
            d = b[4*k +: 4];
            r[8*k +: 8] = tbl[d] | ((k == 1) ? 8'h80 : 8'h00);
        end
        return r;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            bit tk, cl, fu, rn, ln;
            int nn, pn;
            if (rst) begin
                n_m[i] = 0; p_m[i] = 0; run_m[i] = 0; lap_m[i] = 0; ovf_m[i] = 0;
                seg_m[i] = seg_of(16'h0000);
            end else begin
                tk = run_m[i] && (p_m[i] == DIV - 1);
                cl = clr && !run_m[i];
                fu = tk && (n_m[i] == mod_c[i] - 1);
                if (cl)      nn = 0;
                else if (fu) nn = wr_c[i] ? 0 : n_m[i];
                else if (tk) nn = n_m[i] + 1;
                else         nn = n_m[i];
                if (cl)            pn = 0;
                else if (run_m[i]) pn = tk ? 0 : p_m[i] + 1;
                else               pn = p_m[i];
                rn = (fu && !wr_c[i]) ? 1'b0 : (run_m[i] ^ start);
                if (cl)       ln = 1'b0;
                else if (lap) ln = run_m[i] ? !lap_m[i] : 1'b0;
                else          ln = lap_m[i];
                if (ln && !lap_m[i]) seg_m[i] = seg_of(to_bcd(nn, mm_c[i]));
                else if (!ln)        seg_m[i] = seg_of(to_bcd(n_m[i], mm_c[i]));
                ovf_m[i] = cl ? 1'b0 : (ovf_m[i] | fu);
                n_m[i] = nn; p_m[i] = pn; run_m[i] = rn; lap_m[i] = ln;
            end
        end
        model_ok = 1'b1;
    end

    // Per-cycle comparison of every instance against the model.
    always @(negedge clk) begin
        if (model_ok) begin
            for (int i = 0; i < 3; i++) begin
                logic [50:0] got, want;
                got  = {cnt[i], seg[i], run[i], lapa[i], ovf[i]};
                want = {to_bcd(n_m[i], mm_c[i]), seg_m[i], run_m[i], lap_m[i], ovf_m[i]};
                total++;
                if (got !== want) begin
                    bad++;
                    $display("FAIL model dut%0d t=%0t: got cnt=%h seg=%h run=%b lap=%b ovf=%b, want cnt=%h seg=%h run=%b lap=%b ovf=%b",
                             i, $time, cnt[i], seg[i], run[i], lapa[i], ovf[i],
                             want[50:35], want[34:3], want[2], want[1], want[0]);
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input bit s, input bit c, input bit l);
        start = s; clr = c; lap = l;
        cyc(1);
        start = 1'b0; clr = 1'b0; lap = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    initial begin
        cyc(3);
        rst = 1'b0;
        cyc(10);
        check("reset_cnt", 32'(cnt[0]), 32'h0000);
        check("reset_seg", seg[0], 32'h3F3FBF3F);
        check("reset_run", 32'(run[0]), 32'h0);

        pulse(1, 0, 0);
        cyc(40);
        check("run40_cnt", 32'(cnt[0]), 32'h0020);
        pulse(1, 0, 0);
        cyc(20);
        check("stop_hold_cnt", 32'(cnt[0]), 32'h0020);
        check("stop_run", 32'(run[0]), 32'h0);
        pulse(1, 0, 0);
        cyc(1);
        check("resume_phase", 32'(cnt[0]), 32'h0021);

        cyc(1156);
        check("dec_0599", 32'(cnt[0]), 32'h0599);
        check("mmss_0599", 32'(cnt[1]), 32'h0599);
        cyc(2);
        check("dec_0600", 32'(cnt[0]), 32'h0600);
        check("mmss_1000", 32'(cnt[1]), 32'h1000);

        pulse(1, 0, 0);
        pulse(0, 1, 0);
        check("clear_cnt", 32'(cnt[0]), 32'h0000);
        pulse(1, 0, 0);
        cyc(24);
        check("lap_pre_cnt", 32'(cnt[0]), 32'h0012);
        pulse(0, 0, 1);
        cyc(10);
        check("lap_seg_frozen", seg[0], 32'h3F3F865B);
        check("lap_cnt_live", 32'(cnt[0]), 32'h0017);
        check("lap_active", 32'(lapa[0]), 32'h1);
        pulse(0, 0, 1);
        cyc(1);
        check("unlap_seg", seg[0], 32'h3F3F867F);
        check("unlap_flag", 32'(lapa[0]), 32'h0);

        pulse(0, 1, 0);
        check("clear_running_ignored", 32'(cnt[0]), 32'h0019);
        pulse(1, 0, 0);
        pulse(0, 1, 0);
        check("clear_stopped", 32'(cnt[0]), 32'h0000);

        pulse(1, 0, 0);
        cyc(19998);
        check("sat_pre", 32'(cnt[0]), 32'h9999);
        check("wrap_pre", 32'(cnt[2]), 32'h9999);
        cyc(2);
        check("sat_cnt", 32'(cnt[0]), 32'h9999);
        check("sat_ovf", 32'(ovf[0]), 32'h1);
        check("sat_run", 32'(run[0]), 32'h0);
        check("wrap_cnt", 32'(cnt[2]), 32'h0000);
        check("wrap_ovf", 32'(ovf[2]), 32'h1);
        check("wrap_run", 32'(run[2]), 32'h1);
        check("mmss_sat_cnt", 32'(cnt[1]), 32'h9599);
        check("mmss_sat_ovf", 32'(ovf[1]), 32'h1);

        pulse(0, 0, 1);
        pulse(1, 0, 0);
        pulse(0, 1, 1);
        check("clrlap_cnt", 32'(cnt[2]), 32'h0000);
        check("clrlap_ovf", 32'(ovf[2]), 32'h0);
        check("clrlap_lap", 32'(lapa[2]), 32'h0);
        check("running_lap_on", 32'(lapa[0]), 32'h1);

        cyc(3);
        rst = 1'b1;
        cyc(1);
        check("midrst_cnt", 32'(cnt[0]), 32'h0000);
        check("midrst_seg", seg[0], 32'h3F3FBF3F);
        check("midrst_flags", {29'd0, run[0], lapa[0], ovf[0]}, 32'h0);
        rst = 1'b0;
        cyc(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
